// File: rtl/instruction_memory_server_if.sv
// Host load stream and fetch port of the instruction memory server.
// master = host/core side, slave = the memory server.
interface instruction_memory_server_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  load_start;
  logic                  load_valid;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic [ADDR_WIDTH:0]   load_count;
  logic                  loaded;
  logic                  core_start;
  logic                  fetch_en;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] instr;
  logic                  instr_valid;

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_en, fetch_pc,
    input  load_ready, load_count, loaded, core_start, instr, instr_valid
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_en, fetch_pc,
    output load_ready, load_count, loaded, core_start, instr, instr_valid
  );
endinterface

// File: rtl/instruction_memory_server.sv
// Program store: loads a word stream from the host, pulses core_start, then
// serves instr[fetch_pc] with one cycle of latency and stall support.
module instruction_memory_server #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input logic                      clk,
  input logic                      rst,
  instruction_memory_server_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  accept;
  logic                  full;
  logic                  load_done;

  assign bus.load_ready = (state == S_LOAD);
  assign accept         = bus.load_ready && bus.load_valid;
  assign full           = (wr_ptr == '1);
  // Hitting the top address ends the load so the pointer never wraps.
  assign load_done      = accept && (bus.load_last || full);

  // Storage is never cleared; a write aborted by reset does not land.
  always_ff @(posedge clk) begin
    if (accept && !rst) mem[wr_ptr] <= bus.load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      wr_ptr          <= '0;
      bus.load_count  <= '0;
      bus.loaded      <= 1'b0;
      bus.core_start  <= 1'b0;
      bus.instr       <= '0;
      bus.instr_valid <= 1'b0;
    end else begin
      bus.core_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.load_start) begin
            state          <= S_LOAD;
            wr_ptr         <= '0;
            bus.load_count <= '0;
            bus.loaded     <= 1'b0;
          end
        end
        S_LOAD: begin
          bus.instr_valid <= 1'b0;
          if (accept) begin
            bus.load_count <= bus.load_count + CNT_ONE;
            if (load_done) begin
              state          <= S_RUN;
              bus.loaded     <= 1'b1;
              bus.core_start <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + PTR_ONE;
            end
          end
        end
        S_RUN: begin
          // Reload takes priority; the fetch of this cycle is dropped.
          if (bus.load_start) begin
            state           <= S_LOAD;
            wr_ptr          <= '0;
            bus.load_count  <= '0;
            bus.loaded      <= 1'b0;
            bus.instr_valid <= 1'b0;
          end else if (bus.fetch_en) begin
            bus.instr       <= mem[bus.fetch_pc];
            bus.instr_valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_memory_server.sv
// Randomised + directed bench for instruction_memory_server (ADDR_WIDTH = 3)
// against a behavioural model of the load / run protocol.
module tb_instruction_memory_server;
  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 2**AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_memory_server_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

  instruction_memory_server #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // Model: mode 0 = idle, 1 = loading, 2 = running.
  int          m_mode;
  int          m_cnt;
  bit          m_loaded, m_start, m_vld;
  logic [31:0] m_instr;
  logic [31:0] m_mem [DEPTH];
  int          n_checks, n_err, n_pulse, cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick(input bit r, input bit ls, input bit lv, input bit ll,
                      input logic [31:0] ld, input bit fe, input logic [AW-1:0] pc);
    rst            = r;
    ifc.load_start = ls;
    ifc.load_valid = lv;
    ifc.load_last  = ll;
    ifc.load_data  = ld;
    ifc.fetch_en   = fe;
    ifc.fetch_pc   = pc;
    if (r) begin
      m_mode = 0; m_cnt = 0; m_loaded = 0; m_start = 0; m_instr = '0; m_vld = 0;
    end else begin
      m_start = 0;
      case (m_mode)
        0: if (ls) begin m_mode = 1; m_cnt = 0; m_loaded = 0; end
        1: begin
          m_vld = 0;
          if (lv) begin
            m_mem[m_cnt] = ld;
            m_cnt++;
            if (ll || m_cnt == DEPTH) begin m_mode = 2; m_loaded = 1; m_start = 1; end
          end
        end
        default: begin
          if (ls) begin
            m_mode = 1; m_cnt = 0; m_loaded = 0; m_vld = 0;
          end else if (fe) begin
            m_instr = m_mem[pc]; m_vld = 1;
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
    if (ifc.core_start === 1'b1) n_pulse++;
    chk("load_ready",  {31'd0, ifc.load_ready},  {31'd0, m_mode == 1});
    chk("load_count",  {28'd0, ifc.load_count},  m_cnt);
    chk("loaded",      {31'd0, ifc.loaded},      {31'd0, m_loaded});
    chk("core_start",  {31'd0, ifc.core_start},  {31'd0, m_start});
    chk("instr_valid", {31'd0, ifc.instr_valid}, {31'd0, m_vld});
    chk("instr",       ifc.instr,                m_instr);
  endtask

  task automatic beat(input logic [31:0] d, input bit last);
    tick(0, 0, 1, last, d, 0, '0);
  endtask

  task automatic fetch(input logic [AW-1:0] pc);
    tick(0, 0, 0, 0, '0, 1, pc);
  endtask

  int p0;
  logic [31:0] w0;

  initial begin
    n_checks = 0; n_err = 0; n_pulse = 0; cyc = 0;
    m_mode = 0; m_cnt = 0; m_loaded = 0; m_start = 0; m_vld = 0; m_instr = '0;
    // Reset, including load_start coincident with reset.
    tick(1, 0, 0, 0, '0, 0, '0);
    tick(1, 1, 0, 0, '0, 0, '0);
    tick(0, 0, 0, 0, '0, 1, '0);
    chk("idle_ready", {31'd0, ifc.load_ready}, 32'd0);

    // Full memory: 8 beats without last, then a 9th beat offered.
    tick(0, 1, 0, 0, '0, 0, '0);
    w0 = $urandom;
    beat(w0, 0);
    for (int i = 1; i < DEPTH; i++) beat($urandom, 0);
    chk("full_count", {28'd0, ifc.load_count}, DEPTH);
    beat(32'hdead_beef, 0);
    chk("full_no_ready", {31'd0, ifc.load_ready}, 32'd0);
    fetch(0);
    chk("mem0_intact", ifc.instr, w0);
    for (int i = 1; i < DEPTH; i++) fetch(AW'(i));

    // Reload during RUN, then basic 4-word load.
    chk("vld_before_reload", {31'd0, ifc.instr_valid}, 32'd1);
    tick(0, 1, 0, 0, '0, 1, 3'd5);
    chk("reload_vld", {31'd0, ifc.instr_valid}, 32'd0);
    chk("reload_loaded", {31'd0, ifc.loaded}, 32'd0);
    p0 = n_pulse;
    beat(32'h11, 0); beat(32'h22, 0); beat(32'h33, 0); beat(32'h44, 1);
    chk("basic_count", {28'd0, ifc.load_count}, 32'd4);
    tick(0, 1'b0, 1, 1, 32'h55, 0, '0);
    tick(0, 0, 0, 0, '0, 0, '0);
    chk("basic_one_pulse", n_pulse - p0, 32'd1);

    // Fetch then stall.
    fetch(0); chk("f0", ifc.instr, 32'h11);
    fetch(1); chk("f1", ifc.instr, 32'h22);
    fetch(2); chk("f2", ifc.instr, 32'h33);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, '0, 0, 3'd3);
    chk("stall_hold", ifc.instr, 32'h33);

    // Reload with gaps; load_last without valid must be ignored.
    tick(0, 1, 0, 0, '0, 1, 3'd1);
    beat(32'hA0A0_0001, 0);
    tick(0, 0, 0, 1, 32'hBAD0_0000, 0, '0);
    tick(0, 0, 0, 0, 32'hBAD0_0001, 0, '0);
    beat(32'hA0A0_0002, 0);
    beat(32'hA0A0_0003, 1);
    chk("gap_count", {28'd0, ifc.load_count}, 32'd3);
    fetch(0); fetch(1); fetch(2);
    chk("gap_w2", ifc.instr, 32'hA0A0_0003);
    fetch(3);
    chk("gap_w3_old", ifc.instr, 32'h44);

    // Reset mid-load after 2 of 5 beats, then restart.
    p0 = n_pulse;
    tick(0, 1, 0, 0, '0, 0, '0);
    beat(32'hC0, 0); beat(32'hC1, 0);
    tick(1, 0, 1, 0, 32'hC2, 0, '0);
    chk("rst_ready", {31'd0, ifc.load_ready}, 32'd0);
    chk("rst_count", {28'd0, ifc.load_count}, 32'd0);
    tick(0, 0, 1, 0, 32'hC3, 1, '0);
    tick(0, 0, 1, 1, 32'hC4, 1, '0);
    chk("rst_no_pulse", n_pulse - p0, 32'd0);
    tick(0, 1, 0, 0, '0, 0, '0);
    beat(32'hD0, 0); beat(32'hD1, 0); beat(32'hD2, 1);
    fetch(0); chk("restart_w0", ifc.instr, 32'hD0);
    fetch(2); fetch(4);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 63) == 0,
           (m_mode == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0,
           $urandom,
           $urandom_range(0, 1) == 1,
           AW'($urandom_range(0, DEPTH-1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
